// File: rtl/loader_pkg.sv
// Shared types and constants for the Z80 program-image RAM loader.
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_OK    = 8'h06;
  localparam logic [7:0] ACK_ERR   = 8'h15;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/ram_loader_if.sv
// Loader bus: UART rx bytes in, RAM write port and frame status out, ack byte out.
interface ram_loader_if #(parameter int ADDR_W = 14);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] ram_addr_w;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output ram_addr_w, ram_din, ram_we, busy, done, error, err_code, tx_data, tx_valid
  );
  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  ram_addr_w, ram_din, ram_we, busy, done, error, err_code, tx_data, tx_valid
  );
endinterface

// File: rtl/loader_timer.sv
// Inter-byte watchdog: cleared by a strobe, held at zero while disabled,
// saturates at TIMEOUT_CYCLES-1 and flags terminal count there.
module loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i)    cnt_d = '0;
    else if (cnt_q != TERM) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // a byte arriving on the terminal cycle beats the timeout
  assign tc_o = en_i && !clr_i && (cnt_q == TERM);
endmodule

// File: rtl/ram_loader.sv
// Framed UART-to-RAM loader for the Z80 program image.
// Optional ack byte on the tx side when LOADER_ACK_EN is defined.
module ram_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W         = 14,
  parameter int          MEM_DEPTH      = 15360,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic          clk,
  input logic          rst,
  ram_loader_if.master bus
);
  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d, len_q, len_d;
  logic [7:0]        csum_q, csum_d, wdin_q, wdin_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              range_q, range_d, busy_q, busy_d, we_q, we_d;
  logic              done_q, done_d, error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              fin_ok, fin_err, tc;

  loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .clr_i(bus.rx_valid), .en_i(state_q != S_IDLE), .tc_o(tc)
  );

  always_comb begin
    state_d = state_q;  addr_d = addr_q;  len_d = len_q;  csum_d = csum_q;
    range_d = range_q;  busy_d = busy_q;  err_code_d = err_code_q;
    waddr_d = waddr_q;  wdin_d = wdin_q;
    we_d = 1'b0;  done_d = 1'b0;  error_d = 1'b0;  fin_ok = 1'b0;  fin_err = 1'b0;
    if (bus.rx_valid) begin
      if (state_q != S_IDLE) csum_d = csum_q + bus.rx_data;
      case (state_q)
        S_IDLE: if (bus.rx_data == SYNC_BYTE) begin
          state_d = S_ADDR_HI;  busy_d = 1'b1;  err_code_d = ERR_NONE;
          csum_d  = 8'h00;      range_d = 1'b0;
        end
        S_ADDR_HI: begin addr_d[15:8] = bus.rx_data; state_d = S_ADDR_LO; end
        S_ADDR_LO: begin addr_d[7:0]  = bus.rx_data; state_d = S_LEN_HI;  end
        S_LEN_HI:  begin len_d[15:8]  = bus.rx_data; state_d = S_LEN_LO;  end
        S_LEN_LO: begin
          len_d[7:0] = bus.rx_data;
          state_d    = ({len_q[15:8], bus.rx_data} == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          // out-of-range bytes are dropped but still consume length and checksum
          we_d    = ({1'b0, addr_q} < DEPTH);
          range_d = range_q | ~we_d;
          waddr_d = addr_q[ADDR_W-1:0];
          wdin_d  = bus.rx_data;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
          if (len_q == 16'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;  busy_d = 1'b0;
          if (csum_d != 8'h00) begin error_d = 1'b1; err_code_d = ERR_CSUM;  end
          else if (range_q)    begin error_d = 1'b1; err_code_d = ERR_RANGE; end
          else                 done_d = 1'b1;
          fin_ok  = done_d;
          fin_err = error_d;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tc) begin
      state_d = S_IDLE;  busy_d = 1'b0;  error_d = 1'b1;  err_code_d = ERR_TIMEOUT;
      fin_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  addr_q <= '0;  len_q <= '0;  csum_q <= '0;
      range_q <= 1'b0;    busy_q <= 1'b0; we_q <= 1'b0; waddr_q <= '0; wdin_q <= '0;
      done_q  <= 1'b0;    error_q <= 1'b0; err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;  addr_q <= addr_d;  len_q <= len_d;  csum_q <= csum_d;
      range_q <= range_d;  busy_q <= busy_d;  we_q <= we_d;  waddr_q <= waddr_d;
      wdin_q  <= wdin_d;   done_q <= done_d;  error_q <= error_d; err_code_q <= err_code_d;
    end
  end

  assign bus.ram_addr_w = waddr_q;
  assign bus.ram_din    = wdin_q;
  assign bus.ram_we     = we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_code_q;

`ifdef LOADER_ACK_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  // a fresh frame end replaces any ack still waiting for the transmitter
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (fin_ok || fin_err) begin
      tx_valid_d = 1'b1;
      tx_data_d  = fin_ok ? ACK_OK : ACK_ERR;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
`else
  logic [2:0] unused_ack;
  assign unused_ack   = {bus.tx_ready, fin_ok, fin_err};
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h00;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: good, bad-checksum, range, zero-length,
// timeout and mid-frame reset frames; ack byte when LOADER_ACK_EN is set.
module tb_ram_loader;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_loader_if #(.ADDR_W(14)) bus ();

  ram_loader #(.ADDR_W(14), .MEM_DEPTH(15360), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, errs = 0;
  int cyc = 0, last_rx = 0, err_cyc = 0;
  int nwr = 0, ndone = 0, nerr = 0;
  logic [13:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  logic        wr_ok   [16];

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.ram_we) begin
      if (nwr < 16) begin
        wr_addr[nwr] = bus.ram_addr_w;
        wr_data[nwr] = bus.ram_din;
        wr_ok[nwr]   = (cyc == last_rx + 1);
      end
      nwr++;
    end
    if (bus.done) ndone++;
    if (bus.error) begin nerr++; err_cyc = cyc; end
    if (bus.rx_valid) last_rx = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    nwr = 0; ndone = 0; nerr = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] f [], input int gap);
    foreach (f[i]) send(f[i], gap);
  endtask

  logic [7:0] good [] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
  logic [7:0] bad  [] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
  logic [7:0] rng  [] = '{8'hA5, 8'h3B, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h5F};
  logic [7:0] zero [] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
  logic [7:0] ga   [] = '{8'h11, 8'h22, 8'h33};

  initial begin
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_we",   bus.ram_we, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err",  bus.error, 1'b0);
    chk("rst_code", bus.err_code, 2'b00);
    chk("rst_txv",  bus.tx_valid, 1'b0);
    rst = 1'b0;
    tick();

    // good frame, bytes 20 clocks apart
    clr_mon();
    send(8'hA5, 20);
    chk("good_busy_mid", bus.busy, 1'b1);
    for (int i = 1; i < 9; i++) send(good[i], 20);
    chk("good_nwr", nwr, 3);
    for (int i = 0; i < 3; i++) begin
      chk("good_addr", wr_addr[i], 14'h0010 + 14'(i));
      chk("good_data", wr_data[i], ga[i]);
      chk("good_lat",  wr_ok[i], 1'b1);
    end
    chk("good_done", ndone, 1);
    chk("good_nerr", nerr, 0);
    chk("good_code", bus.err_code, 2'b00);
    chk("good_busy_end", bus.busy, 1'b0);
`ifndef LOADER_ACK_EN
    chk("noack_txv", bus.tx_valid, 1'b0);
    chk("noack_txd", bus.tx_data, 8'h00);
`endif

    // bad checksum: writes still posted
    clr_mon();
    send_frame(bad, 4);
    chk("bad_nwr", nwr, 3);
    chk("bad_data2", wr_data[2], 8'h33);
    chk("bad_nerr", nerr, 1);
    chk("bad_done", ndone, 0);
    chk("bad_code", bus.err_code, 2'b01);

    // range: second byte lands at 0x3C00 = MEM_DEPTH
    clr_mon();
    send_frame(rng, 4);
    chk("rng_nwr", nwr, 1);
    chk("rng_addr", wr_addr[0], 14'h3BFF);
    chk("rng_data", wr_data[0], 8'hAA);
    chk("rng_nerr", nerr, 1);
    chk("rng_code", bus.err_code, 2'b10);

    // zero length
    clr_mon();
    send_frame(zero, 4);
    chk("zero_nwr", nwr, 0);
    chk("zero_done", ndone, 1);
    chk("zero_code", bus.err_code, 2'b00);

    // timeout after address bytes
    clr_mon();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    for (int i = 0; i < 300 && nerr == 0; i++) tick();
    chk("to_nerr", nerr, 1);
    chk("to_lat", err_cyc - last_rx, TO + 1);
    chk("to_code", bus.err_code, 2'b11);
    chk("to_busy", bus.busy, 1'b0);
    chk("to_nwr", nwr, 0);

    // reset lands together with a data byte mid-frame
    clr_mon();
    send(8'hA5, 2); send(8'h00, 2); send(8'h20, 2); send(8'h00, 2); send(8'h04, 2);
    send(8'h11, 2);
    bus.rx_data = 8'h22; bus.rx_valid = 1'b1; rst = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    chk("mrst_we",   bus.ram_we, 1'b0);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_code", bus.err_code, 2'b00);
    chk("mrst_err",  bus.error, 1'b0);
    rst = 1'b0;
    repeat (TO + 20) tick();
    chk("mrst_nwr", nwr, 1);
    chk("mrst_addr", wr_addr[0], 14'h0020);
    chk("mrst_nerr", nerr, 0);

`ifdef LOADER_ACK_EN
    for (int i = 0; i < 8; i++) send(good[i], 2);
    bus.tx_ready = 1'b0;
    send(good[8], 0);
    chk("ack_txv", bus.tx_valid, 1'b1);
    chk("ack_txd", bus.tx_data, 8'h06);
    repeat (5) tick();
    chk("ack_hold_v", bus.tx_valid, 1'b1);
    chk("ack_hold_d", bus.tx_data, 8'h06);
    bus.tx_ready = 1'b1;
    tick();
    chk("ack_drop", bus.tx_valid, 1'b0);
    bus.tx_ready = 1'b0;
    send_frame(bad, 1);
    chk("nak_txv", bus.tx_valid, 1'b1);
    chk("nak_txd", bus.tx_data, 8'h15);
    bus.tx_ready = 1'b1;
    tick();
    chk("nak_drop", bus.tx_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side master for the 15 KiB dual-port block RAM that holds the Z80 program image.
- Parses a framed byte stream from the UART receiver and drives the RAM write port (address, data, write enable).
- Keeps the CPU held off (busy) while a frame is in progress.
- Reports completion or error per frame.

Parameters:
- ADDR_W, 14, width of the RAM write address.
- MEM_DEPTH, 15360, number of valid RAM locations (0 .. MEM_DEPTH-1).
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte, valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per byte; no backpressure.
- ram_addr_w  output  ADDR_W  RAM write address.
- ram_din  output  8  RAM write data.
- ram_we  output  1  RAM write enable, one cycle per byte.
- busy  output  1  high from sync byte accepted until frame end or abort.
- done  output  1  one-cycle pulse when a frame ends without error.
- error  output  1  one-cycle pulse when a frame ends in error or aborts.
- err_code  output  2  cause, held until the next frame starts: 00 none, 01 checksum, 10 range, 11 timeout.
- tx_data  output  8  ack byte (see Optional Feature).
- tx_valid  output  1  ack byte valid.
- tx_ready  input  1  UART transmitter can accept a byte.

Behaviour:
- Frame format: 0xA5, addr_hi, addr_lo, len_hi, len_lo, len data bytes, csum.
  - csum is chosen so that the 8-bit sum of all bytes after 0xA5, including csum, equals 0x00.
- Reset values: all outputs 0, state IDLE, err_code 00, internal counters 0.
- States: IDLE -> ADDR_HI -> ADDR_LO -> LEN_HI -> LEN_LO -> DATA -> CSUM -> IDLE.
  - Each transition occurs on an rx_valid cycle.
  - IDLE ignores every byte except 0xA5.
  - LEN_LO goes directly to CSUM when len=0.
- On leaving IDLE: busy goes high the cycle after 0xA5 is accepted; err_code cleared; checksum accumulator cleared.
- Write path:
  - A data byte accepted at cycle N produces ram_we=1 at N+1, with ram_din=byte and ram_addr_w=cur_addr[ADDR_W-1:0].
  - cur_addr (16-bit) then increments and wraps 0xFFFF -> 0x0000.
  - Writes are posted immediately; a later checksum failure does not undo them.
- Range rule: if cur_addr >= MEM_DEPTH, ram_we is suppressed for that byte and a range flag is set; parsing continues.
- Frame end (CSUM byte accepted at cycle N), with outputs at N+1:
  - If the checksum sum != 0: error=1, err_code=01.
  - Else if the range flag is set: error=1, err_code=10.
  - Else: done=1.
  - In all cases busy=0 and state returns to IDLE.
- Timeout:
  - The counter resets on every rx_valid and runs only while not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1: return to IDLE, error=1, err_code=11, busy=0, no further writes.
- rx_valid in the same cycle as the timeout terminal count: the byte wins and the counter resets.
- A 0xA5 received mid-frame is treated as ordinary data; there is no resync.
- rst mid-frame: the next edge returns to IDLE with all outputs 0; a pending ram_we is cancelled.

Optional Feature:
- Macro: LOADER_ACK_EN.
- Defined:
  - After each frame end or timeout, tx_data is driven with 0x06 (ok) or 0x15 (error) and tx_valid is held until tx_ready is sampled high.
  - A new 0xA5 received while the ack is pending is still accepted and does not drop the ack.
- Undefined: tx_data=0 and tx_valid=0 permanently; tx_ready is ignored.

Decomposition:
- Package loader_pkg: state enum, SYNC_BYTE=8'hA5, ACK_OK=8'h06, ACK_ERR=8'h15, err_code constants.
- Sub-module loader_timer: clear-on-strobe, enable-gated terminal-count counter sized by TIMEOUT_CYCLES.

Test Plan:
- Good frame:
  - Stimulus: A5 00 10 00 03 11 22 33 87, bytes spaced 20 clocks apart.
  - Required: writes 0x0010=11, 0x0011=22, 0x0012=33, each one clock after its byte; done pulse; err_code 00; busy low after the final byte.
- Bad checksum:
  - Stimulus: same frame with csum 88.
  - Required: same three writes occur; error pulse; err_code 01; no done.
- Range:
  - Stimulus: A5 3B FF 00 02 AA BB 5F.
  - Required: write 0x3BFF=AA only; second write suppressed; error pulse; err_code 10.
- Zero length:
  - Stimulus: A5 01 00 00 00 FF.
  - Required: no ram_we; done pulse.
- Timeout and reset:
  - Stimulus: A5 00 00 then silence for TIMEOUT_CYCLES (bench uses 100).
  - Required: error pulse with err_code 11.
  - Then: a new frame with rst asserted mid-DATA yields no ram_we after rst and all outputs 0.
- With LOADER_ACK_EN:
  - Stimulus: good frame, with tx_ready held low for 5 clocks.
  - Required: tx_data=06 and tx_valid held stable until tx_ready=1, then tx_valid drops.
  - A bad frame yields tx_data=15.
